// File: rtl/enc_event_queue.sv
// Event capture queue behind the 8-to-3 encoder: detects new active codes and buffers them in a FIFO.
// Optional macro ENC_EVQ_TIMESTAMP_EN adds a free-running timestamp stored alongside each entry.
module enc_event_queue #(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 3,
    parameter int TS_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [CODE_W-1:0]        code,
    input  logic                     active,
    input  logic                     clr,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [CODE_W-1:0]        rd_code,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow
`ifdef ENC_EVQ_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]          rd_ts
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [CODE_W-1:0] code_q;
    logic              active_q;
    logic [CODE_W-1:0] code_mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              full_i;
    logic              evt;
    logic              pop;
    logic              push;
    logic              drop;

    // Previous-cycle view of the encoder, tracked even while capture is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q   <= '0;
            active_q <= 1'b0;
        end else begin
            code_q   <= code;
            active_q <= active;
        end
    end

    assign full_i = (cnt == CNT_W'(DEPTH));

    always_comb begin
        evt  = en & active & (~active_q | (code != code_q));
        pop  = (cnt != '0) & rd_ready & ~clr;
        push = evt & ~clr & (~full_i | pop);
        drop = evt & ~clr & full_i & ~pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer increments wrap naturally.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if (drop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) code_mem[i] <= '0;
        end else if (push) begin
            code_mem[wr_ptr] <= code;
        end
    end

    assign rd_valid = (cnt != '0);
    assign rd_code  = code_mem[rd_ptr];
    assign count    = cnt;
    assign full     = full_i;
    assign overflow = ovf;

`ifdef ENC_EVQ_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_mem [DEPTH];

    // Free-running; clr deliberately leaves it alone so timestamps stay monotonic across clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_cnt <= '0;
        else        ts_cnt <= ts_cnt + TS_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ts_mem[i] <= '0;
        end else if (push) begin
            ts_mem[wr_ptr] <= ts_cnt;
        end
    end

    assign rd_ts = ts_mem[rd_ptr];
`else
    logic [TS_W-1:0] ts_unused;
    assign ts_unused = '0;
`endif

endmodule

// File: tb/tb_enc_event_queue.sv
// Scoreboard bench for enc_event_queue: a reference model predicts every cycle, expected
// entries are queued at push time and compared when the consumer pops them.
module tb_enc_event_queue;

    localparam int DEPTH  = 4;
    localparam int CODE_W = 3;
    localparam int TS_W   = 8;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [CODE_W-1:0] code;
    logic              active;
    logic              clr;
    logic              rd_valid;
    logic              rd_ready;
    logic [CODE_W-1:0] rd_code;
    logic [2:0]        count;
    logic              full;
    logic              overflow;
`ifdef ENC_EVQ_TIMESTAMP_EN
    logic [TS_W-1:0]   rd_ts;
`endif

    enc_event_queue #(.DEPTH(DEPTH), .CODE_W(CODE_W), .TS_W(TS_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .code     (code),
        .active   (active),
        .clr      (clr),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_code  (rd_code),
        .count    (count),
        .full     (full),
        .overflow (overflow)
`ifdef ENC_EVQ_TIMESTAMP_EN
        ,
        .rd_ts    (rd_ts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CODE_W-1:0] code;
        logic [TS_W-1:0]   ts;
    } ent_t;

    ent_t              exp_q[$];
    logic [CODE_W-1:0] m_code_q;
    logic              m_active_q;
    logic              m_ovf;
    logic [TS_W-1:0]   m_ts;
    int                n_chk;
    int                n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_state();
        check("rd_valid", {31'd0, rd_valid}, {31'd0, exp_q.size() != 0});
        check("count", {29'd0, count}, exp_q.size());
        check("full", {31'd0, full}, {31'd0, exp_q.size() == DEPTH});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (exp_q.size() != 0) begin
            check("head_code", {29'd0, rd_code}, {29'd0, exp_q[0].code});
`ifdef ENC_EVQ_TIMESTAMP_EN
            check("head_ts", {24'd0, rd_ts}, {24'd0, exp_q[0].ts});
`endif
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, advance the model, cross the edge.
    task automatic step(input logic e, input logic a, input logic [CODE_W-1:0] c,
                        input logic r, input logic cl);
        logic evt;
        logic pop;
        logic was_full;
        ent_t ent;
        check_state();
        en = e; active = a; code = c; rd_ready = r; clr = cl;
        evt      = e && a && (!m_active_q || (c != m_code_q));
        pop      = r && (exp_q.size() != 0) && !cl;
        was_full = (exp_q.size() == DEPTH);
        if (cl) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) begin
                ent = exp_q.pop_front();
                check("pop_code", {29'd0, rd_code}, {29'd0, ent.code});
            end
            if (evt) begin
                if (!was_full || pop) begin
                    ent.code = c;
                    ent.ts   = m_ts;
                    exp_q.push_back(ent);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        m_code_q   = c;
        m_active_q = a;
        m_ts       = m_ts + 8'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_code_q   = '0;
        m_active_q = 1'b0;
        m_ovf      = 1'b0;
        m_ts       = '0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_code", {29'd0, rd_code}, 32'd0);
`ifdef ENC_EVQ_TIMESTAMP_EN
        check("rst_ts", {24'd0, rd_ts}, 32'd0);
`endif
        model_reset();
        en = 1'b0; active = 1'b0; code = '0; rd_ready = 1'b0; clr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b1;
        en = 1'b0; active = 1'b0; code = '0; rd_ready = 1'b0; clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        async_reset();

        // 1: held code gives exactly one entry, then push+pop at count 1 replaces the head
        for (int i = 0; i < 4; i++) step(1, 1, 3'd5, 0, 0);
        check_state();
        check("t1_count", {29'd0, count}, 32'd1);
        check("t1_code", {29'd0, rd_code}, 32'd5);
        step(1, 1, 3'd6, 1, 0);
        check("t1_pp_count", {29'd0, count}, 32'd1);
        check("t1_pp_code", {29'd0, rd_code}, 32'd6);
        step(0, 0, 3'd0, 1, 0);

        // 2: sequence 1,2,3,3,7 fills the queue, then drains in order
        step(1, 1, 3'd1, 0, 0);
        step(1, 1, 3'd2, 0, 0);
        step(1, 1, 3'd3, 0, 0);
        step(1, 1, 3'd3, 0, 0);
        step(1, 1, 3'd7, 0, 0);
        check("t2_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < 4; i++) step(0, 1, 3'd7, 1, 0);
        check("t2_ovf", {31'd0, overflow}, 32'd0);

        // 3: overflow when full, then full with simultaneous pop accepts
        step(1, 0, 3'd0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 3'(i), 0, 0);
        step(1, 1, 3'd4, 0, 0);
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        step(0, 0, 3'd0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 3'(i + 2), 0, 0);
        step(1, 1, 3'd1, 1, 0);
        check("t3_noovf", {31'd0, overflow}, 32'd0);
        check("t3_count", {29'd0, count}, 32'd4);
        for (int i = 0; i < 4; i++) step(0, 0, 3'd0, 1, 0);

        // 4: en low blocks events; held code with active_q already high gives none
        for (int i = 0; i < 8; i++) step(0, 1, 3'(i), 0, 0);
        step(1, 1, 3'd7, 0, 0);
        step(1, 1, 3'd7, 0, 0);
        check("t4_none", {29'd0, count}, 32'd0);
        step(1, 1, 3'd6, 0, 0);
        step(1, 0, 3'd6, 0, 0);
        step(1, 1, 3'd6, 0, 0);
        check("t4_two", {29'd0, count}, 32'd2);
        step(0, 0, 3'd0, 1, 0);
        step(0, 0, 3'd0, 1, 0);

        // 5: three entries with overflow, clr with a coincident event, then reset mid-stream
        for (int i = 0; i < 5; i++) step(1, 1, 3'(7 - i), 0, 0);
        step(0, 1, 3'd0, 1, 0);
        check("t5_pre", {29'd0, count}, 32'd3);
        step(1, 1, 3'd5, 0, 1);
        check("t5_clr_cnt", {29'd0, count}, 32'd0);
        check("t5_clr_ovf", {31'd0, overflow}, 32'd0);
        step(1, 1, 3'd1, 0, 0);
        step(1, 1, 3'd2, 0, 0);
        step(1, 1, 3'd3, 1, 0);
        async_reset();
        step(0, 0, 3'd0, 0, 0);

`ifdef ENC_EVQ_TIMESTAMP_EN
        // 6: timestamps across the counter wrap
        async_reset();
        while (m_ts != 8'd254) step(0, 0, 3'd0, 0, 0);
        step(1, 1, 3'd1, 0, 0);
        while (m_ts != 8'd2) step(0, 0, 3'd0, 0, 0);
        step(1, 1, 3'd2, 0, 0);
        check("t6_ts0", {24'd0, rd_ts}, 32'd254);
        step(0, 0, 3'd0, 1, 0);
        check("t6_ts1", {24'd0, rd_ts}, 32'd2);
        step(0, 0, 3'd0, 1, 0);
`endif

        check_state();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
